// File: rtl/csel_pkg.sv
// rtl/csel_pkg.sv - default parameters and stage slice helpers for the pipelined carry-select adder/subtractor
package csel_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_BLOCK  = 4;
    localparam int DEF_STAGES = 2;

    function automatic int slice_lo(input int k, input int width, input int stages);
        return k * (width / stages);
    endfunction

    function automatic int slice_hi(input int k, input int width, input int stages);
        return (k + 1) * (width / stages) - 1;
    endfunction

endpackage

// File: rtl/csel_block.sv
// rtl/csel_block.sv - one carry-select block: two ripple adders (carry 0 and 1) muxed by the incoming carry
module csel_block
    import csel_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_sum,
    output logic             o_cout
);

    logic [BLOCK-1:0] w_sum0;
    logic [BLOCK-1:0] w_sum1;
    logic [BLOCK:0]   w_c0;
    logic [BLOCK:0]   w_c1;

    always_comb begin
        w_sum0 = '0;
        w_sum1 = '0;
        w_c0   = '0;
        w_c1   = '0;
        w_c1[0] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            w_sum0[i]  = i_a[i] ^ i_b[i] ^ w_c0[i];
            w_c0[i+1]  = (i_a[i] & i_b[i]) | (w_c0[i] & (i_a[i] ^ i_b[i]));
            w_sum1[i]  = i_a[i] ^ i_b[i] ^ w_c1[i];
            w_c1[i+1]  = (i_a[i] & i_b[i]) | (w_c1[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_sum  = i_cin ? w_sum1 : w_sum0;
    assign o_cout = i_cin ? w_c1[BLOCK] : w_c0[BLOCK];

endmodule

// File: rtl/pipe_csel_addsub.sv
// rtl/pipe_csel_addsub.sv - STAGES-deep valid/ready pipelined carry-select adder/subtractor
// Stage k adds slice k; operands, partial sums and the slice carry travel with the beat.
module pipe_csel_addsub
    import csel_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int BLOCK  = DEF_BLOCK,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NB  = WIDTH / BLOCK;
    localparam int NBS = NB / STAGES;
    localparam int SW  = WIDTH / STAGES;

    if ((WIDTH % BLOCK != 0) || (NB % STAGES != 0)) begin : g_bad_params
        $error("pipe_csel_addsub: WIDTH must split into whole BLOCK-bit blocks spread evenly over STAGES");
    end

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_st_cin;
    logic [STAGES-1:0] w_st_cout;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic              r_cm;
    logic              w_cmsb;
    logic [WIDTH-1:0]  w_b_eff;
    logic [WIDTH-1:0]  w_blk_sum;

    // Subtraction is a + ~b + !cin, so borrow-in becomes an inverted carry-in.
    assign w_b_eff     = op_sub ? ~b : b;
    assign w_st_cin[0] = op_sub ? ~cin : cin;

    for (genvar k = 1; k < STAGES; k++) begin : g_cin
        assign w_st_cin[k] = r_c[k-1];
    end

    for (genvar g = 0; g < NB; g++) begin : g_blk
        localparam int K = g / NBS;
        logic [BLOCK-1:0] w_a;
        logic [BLOCK-1:0] w_b;
        logic             w_cin;
        logic             w_cout;

        if (K == 0) begin : g_src_in
            assign w_a = a[g*BLOCK +: BLOCK];
            assign w_b = w_b_eff[g*BLOCK +: BLOCK];
        end else begin : g_src_reg
            assign w_a = r_a[K-1][g*BLOCK +: BLOCK];
            assign w_b = r_b[K-1][g*BLOCK +: BLOCK];
        end

        if (g % NBS == 0) begin : g_cin_stage
            assign w_cin = w_st_cin[K];
        end else begin : g_cin_chain
            assign w_cin = g_blk[g-1].w_cout;
        end

        csel_block #(.BLOCK(BLOCK)) u_blk (
            .i_a    (w_a),
            .i_b    (w_b),
            .i_cin  (w_cin),
            .o_sum  (w_blk_sum[g*BLOCK +: BLOCK]),
            .o_cout (w_cout)
        );

        if (g % NBS == NBS - 1) begin : g_stage_cout
            assign w_st_cout[K] = w_cout;
        end

        // Carry into the MSB recovered from the MSB sum bit and its operands.
        if (g == NB - 1) begin : g_msb
            assign w_cmsb = w_blk_sum[WIDTH-1] ^ w_a[BLOCK-1] ^ w_b[BLOCK-1];
        end
    end

    always_comb begin
        w_adv  = '0;
        w_load = '0;
        w_adv[STAGES-1]  = r_vld[STAGES-1] & out_ready;
        w_load[STAGES-1] = ~r_vld[STAGES-1] | w_adv[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k]  = r_vld[k] & w_load[k+1];
            w_load[k] = ~r_vld[k] | w_adv[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (w_load[0]) r_vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (w_load[k]) r_vld[k] <= r_vld[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load[0]) begin
            r_a[0]   <= a;
            r_b[0]   <= w_b_eff;
            r_c[0]   <= w_st_cout[0];
            r_sum[0] <= '0;
            r_sum[0][SW-1:0] <= w_blk_sum[SW-1:0];
        end
        for (int k = 1; k < STAGES; k++) begin
            if (w_load[k]) begin
                r_a[k]   <= r_a[k-1];
                r_b[k]   <= r_b[k-1];
                r_c[k]   <= w_st_cout[k];
                r_sum[k] <= r_sum[k-1];
                r_sum[k][slice_lo(k, WIDTH, STAGES) +: SW] <= w_blk_sum[slice_lo(k, WIDTH, STAGES) +: SW];
            end
        end
        if (w_load[STAGES-1]) r_cm <= w_cmsb;
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_vld[STAGES-1];
    assign sum       = out_valid ? r_sum[STAGES-1] : '0;
    assign cout      = out_valid & r_c[STAGES-1];
    assign ovf       = out_valid & (r_cm ^ r_c[STAGES-1]);
    assign zero      = out_valid & (r_sum[STAGES-1] == '0);

endmodule
